// File: rtl/par_pkg.sv
// Shared definitions for the parallel byte link (transmitter and receiver).
//   PAR_WIDTH      : byte width on the data/stb/ack/rdy handshake
//   par_tx_state_t : transmitter handshake FSM states
package par_pkg;

  localparam int PAR_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    STROBE   = 2'b01,
    WAIT_RDY = 2'b10
  } par_tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered, exact occupancy count.
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   push       : write push_data when not full
//   pop        : drop the head entry when not empty
//   head       : current head entry (valid while !empty)
//   full/empty : occupancy flags derived from count
//   count      : number of stored entries, 0..DEPTH
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; entries are only read after being written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/parallel_tx.sv
// Parallel byte transmitter: buffers bytes from a valid/ready producer and
// presents them one at a time on the data/stb/ack/rdy handshake, aborting a
// strobe that sees no ack within TIMEOUT cycles and retrying the same byte.
//   clk, rst_n  : clock, asynchronous active-low reset
//   in_data     : byte from producer
//   in_valid    : producer has a byte
//   in_ready    : FIFO can accept (not full)
//   data, stb   : byte and strobe to receiver
//   ack         : receiver accepted the byte
//   rdy         : receiver idle and able to take a byte
//   fifo_count  : current FIFO occupancy
//   timeout_err : one-cycle pulse when a strobe times out
module parallel_tx
  import par_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [PAR_WIDTH-1:0]   in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [PAR_WIDTH-1:0]   data,
  output logic                   stb,
  input  logic                   ack,
  input  logic                   rdy,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   timeout_err
);

  localparam int CW = $clog2(TIMEOUT);

  par_tx_state_t        state, state_nxt;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic [PAR_WIDTH-1:0] data_nxt;
  logic                 stb_nxt;
  logic                 terr_nxt;
  logic                 pop;
  logic                 push;
  logic                 full;
  logic                 empty;
  logic [PAR_WIDTH-1:0] head;

  assign in_ready = !full;
  assign push     = in_valid && !full;

  sync_fifo #(
    .WIDTH (PAR_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (in_data),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      data        <= '0;
      stb         <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      data        <= data_nxt;
      stb         <= stb_nxt;
      timeout_err <= terr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    data_nxt  = data;
    stb_nxt   = 1'b0;
    terr_nxt  = 1'b0;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && rdy) begin
          data_nxt  = head;
          stb_nxt   = 1'b1;
          cnt_nxt   = '0;
          state_nxt = STROBE;
        end
      end
      STROBE: begin
        stb_nxt = 1'b1;
        // ack is tested first so a late ack on the last cycle still delivers.
        if (ack) begin
          pop       = 1'b1;
          stb_nxt   = 1'b0;
          state_nxt = WAIT_RDY;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          stb_nxt   = 1'b0;
          terr_nxt  = 1'b1;
          state_nxt = WAIT_RDY;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      WAIT_RDY: begin
        if (!ack && rdy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_parallel_tx.sv
module tb_parallel_tx;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] data;
  logic       stb;
  logic       ack;
  logic       rdy;
  logic [2:0] fifo_count;
  logic       timeout_err;

  int pass_cnt = 0;
  int total    = 0;

  parallel_tx #(
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .data        (data),
    .stb         (stb),
    .ack         (ack),
    .rdy         (rdy),
    .fifo_count  (fifo_count),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       r;
    logic       a;
    logic       e_stb;
    logic [7:0] e_data;
    int         e_cnt;
    logic       e_rdy;
    logic       e_terr;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h @%0t", name, act, exp, $time);
    else pass_cnt++;
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_stb(input int max_cycles);
    int n = 0;
    while (!stb && n < max_cycles) begin
      step();
      n++;
    end
    chk("stb_rise_in_time", 32'(stb), 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic add(input logic v, input logic [7:0] d, input logic r, input logic a,
                     input logic es, input logic [7:0] ed, input int ec,
                     input logic er, input logic et);
    vec_t t;
    t = '{v, d, r, a, es, ed, ec, er, et};
    vecs.push_back(t);
  endtask

  initial begin
    int         hi;
    logic [7:0] q[$];
    int         run;
    bit         exp_terr;
    bit         exp_low;
    bit         popped;
    bit         pushed;
    int         ack_pct;

    rst_n = 1'b0; in_data = '0; in_valid = 1'b0; ack = 1'b0; rdy = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_stb",      32'(stb),         32'd0);
    chk("rst_data",     32'(data),        32'd0);
    chk("rst_count",    32'(fifo_count),  32'd0);
    chk("rst_in_ready", 32'(in_ready),    32'd1);
    chk("rst_terr",     32'(timeout_err), 32'd0);
    rst_n = 1'b1;
    step();

    // Single byte with immediate ack, then fill/overflow and in-order drain.
    add(1, 8'hA5, 1, 0,  0, 8'h00, 1, 1, 0);
    add(0, 8'h00, 1, 0,  1, 8'hA5, 1, 1, 0);
    add(0, 8'h00, 1, 1,  0, 8'hA5, 0, 1, 0);
    add(0, 8'h00, 1, 0,  0, 8'hA5, 0, 1, 0);
    add(1, 8'hA1, 0, 0,  0, 8'hA5, 1, 1, 0);
    add(1, 8'hA2, 0, 0,  0, 8'hA5, 2, 1, 0);
    add(1, 8'hA3, 0, 0,  0, 8'hA5, 3, 1, 0);
    add(1, 8'hA4, 0, 0,  0, 8'hA5, 4, 0, 0);
    add(1, 8'hA5, 0, 0,  0, 8'hA5, 4, 0, 0);
    add(0, 8'h00, 1, 0,  1, 8'hA1, 4, 0, 0);
    add(0, 8'h00, 1, 1,  0, 8'hA1, 3, 1, 0);
    add(0, 8'h00, 1, 0,  0, 8'hA1, 3, 1, 0);
    add(0, 8'h00, 1, 0,  1, 8'hA2, 3, 1, 0);
    add(0, 8'h00, 1, 1,  0, 8'hA2, 2, 1, 0);
    add(0, 8'h00, 1, 0,  0, 8'hA2, 2, 1, 0);
    add(0, 8'h00, 1, 0,  1, 8'hA3, 2, 1, 0);
    add(0, 8'h00, 1, 1,  0, 8'hA3, 1, 1, 0);
    add(0, 8'h00, 1, 0,  0, 8'hA3, 1, 1, 0);
    add(0, 8'h00, 1, 0,  1, 8'hA4, 1, 1, 0);
    add(0, 8'h00, 1, 1,  0, 8'hA4, 0, 1, 0);
    add(0, 8'h00, 1, 0,  0, 8'hA4, 0, 1, 0);
    add(0, 8'h00, 1, 0,  0, 8'hA4, 0, 1, 0);

    foreach (vecs[i]) begin
      in_valid = vecs[i].v; in_data = vecs[i].d; rdy = vecs[i].r; ack = vecs[i].a;
      step();
      chk($sformatf("vec%0d_stb", i),      32'(stb),         32'(vecs[i].e_stb));
      chk($sformatf("vec%0d_data", i),     32'(data),        32'(vecs[i].e_data));
      chk($sformatf("vec%0d_count", i),    32'(fifo_count),  32'(vecs[i].e_cnt));
      chk($sformatf("vec%0d_in_ready", i), 32'(in_ready),    32'(vecs[i].e_rdy));
      chk($sformatf("vec%0d_terr", i),     32'(timeout_err), 32'(vecs[i].e_terr));
    end

    // Timeout after TIMEOUT strobe cycles, then successful retry.
    in_valid = 1'b1; in_data = 8'h3C; rdy = 1'b1; ack = 1'b0;
    step();
    in_valid = 1'b0;
    wait_stb(5);
    hi = 0;
    while (stb && hi < 40) begin
      hi++;
      step();
    end
    chk("to_stb_len",   32'(hi),          32'(TIMEOUT));
    chk("to_terr",      32'(timeout_err), 32'd1);
    chk("to_count",     32'(fifo_count),  32'd1);
    step();
    chk("to_terr_pulse", 32'(timeout_err), 32'd0);
    wait_stb(5);
    chk("retry_data", 32'(data), 32'h3C);
    ack = 1'b1;
    step();
    chk("retry_count", 32'(fifo_count),  32'd0);
    chk("retry_stb",   32'(stb),         32'd0);
    chk("retry_terr",  32'(timeout_err), 32'd0);
    ack = 1'b0;
    step();

    // Ack on the last permitted strobe cycle wins over the timeout.
    in_valid = 1'b1; in_data = 8'h5A;
    step();
    in_valid = 1'b0;
    wait_stb(5);
    for (int i = 1; i < TIMEOUT; i++) step();
    chk("late_ack_stb_held", 32'(stb), 32'd1);
    ack = 1'b1;
    step();
    chk("late_ack_terr",  32'(timeout_err), 32'd0);
    chk("late_ack_count", 32'(fifo_count),  32'd0);
    chk("late_ack_stb",   32'(stb),         32'd0);
    ack = 1'b0;
    step();
    chk("late_ack_terr2", 32'(timeout_err), 32'd0);

    // Simultaneous pop and push with 3 entries.
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 8'(8'h41 + i);
      step();
    end
    in_valid = 1'b0;
    chk("pp_count_pre", 32'(fifo_count), 32'd3);
    rdy = 1'b1;
    wait_stb(5);
    chk("pp_data", 32'(data), 32'h41);
    ack = 1'b1; in_valid = 1'b1; in_data = 8'h44;
    step();
    chk("pp_count",    32'(fifo_count), 32'd3);
    chk("pp_in_ready", 32'(in_ready),   32'd1);
    ack = 1'b0; in_valid = 1'b0;

    // Asynchronous reset while strobing with two bytes queued.
    do_reset();
    rdy = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = 8'(8'h61 + i);
      step();
    end
    in_valid = 1'b0; rdy = 1'b1;
    wait_stb(5);
    chk("ar_count_pre", 32'(fifo_count), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("ar_stb",      32'(stb),         32'd0);
    chk("ar_count",    32'(fifo_count),  32'd0);
    chk("ar_in_ready", 32'(in_ready),    32'd1);
    chk("ar_terr",     32'(timeout_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("ar_idle_stb", 32'(stb), 32'd0);
    in_valid = 1'b1; in_data = 8'h77;
    step();
    in_valid = 1'b0;
    chk("ar_push_count", 32'(fifo_count), 32'd1);
    chk("ar_push_stb0",  32'(stb),        32'd0);
    step();
    chk("ar_push_stb1",  32'(stb),        32'd1);
    chk("ar_push_data",  32'(data),       32'h77);
    ack = 1'b1;
    step();
    ack = 1'b0;
    step();

    // Randomized traffic against a queue-based scoreboard.
    do_reset();
    q.delete();
    run = 0; exp_terr = 1'b0; exp_low = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      ack_pct = ((c / 500) % 2 == 0) ? 60 : 2;
      chk("rnd_count",    32'(fifo_count),  32'(q.size()));
      chk("rnd_in_ready", 32'(in_ready),    32'(q.size() < DEPTH));
      chk("rnd_terr",     32'(timeout_err), 32'(exp_terr));
      if (exp_low) chk("rnd_stb_dropped", 32'(stb), 32'd0);
      if (stb) begin
        run++;
        if (q.size() == 0) chk("rnd_stb_while_empty", 32'd1, 32'(q.size()));
        else chk("rnd_data", 32'(data), 32'(q[0]));
      end else begin
        run = 0;
      end
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 8'($urandom);
      rdy      = ($urandom_range(0, 99) < 85);
      ack      = ($urandom_range(0, 99) < ack_pct);
      popped   = stb && ack;
      exp_terr = stb && !ack && (run == TIMEOUT);
      exp_low  = stb && (ack || run == TIMEOUT);
      pushed   = in_valid && (q.size() < DEPTH);
      if (popped && q.size() > 0) void'(q.pop_front());
      if (pushed) q.push_back(in_data);
      step();
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
